// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_bus_arbiter_pkg                                              |
// | Shared widths, IO window select and FSM encoding for the bus     |
// | arbiter and its byte assembler.                                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mem_bus_arbiter_pkg;

   localparam int         c_INST_ADDR_W = 32;
   localparam int         c_REG_W       = 32;
   localparam logic [1:0] c_IO_SEL      = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_IF_RD   = 3'd1,
      ST_D_RD    = 3'd2,
      ST_D_WR    = 3'd3,
      ST_IO_WAIT = 3'd4
   } state_t;

   // Anything other than a 1- or 2-byte access is handled as a word.
   function automatic logic [2:0] norm_len(input logic [2:0] len);
      case (len)
         3'd1:    norm_len = 3'd1;
         3'd2:    norm_len = 3'd2;
         default: norm_len = 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_assembler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_byte_assembler                                               |
// | 32-bit word register: byte-lane insert for reads, byte extract   |
// | for writes.                                                      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_byte_assembler
   import mem_bus_arbiter_pkg::*;
(
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               load,
   input  logic [c_REG_W-1:0] load_word,
   input  logic               cap_en,
   input  logic [1:0]         cap_lane,
   input  logic [7:0]         cap_byte,
   input  logic [1:0]         rd_lane,
   output logic [c_REG_W-1:0] asm_word,
   output logic [7:0]         rd_byte
);

   logic [c_REG_W-1:0] r_word;
   logic [c_REG_W-1:0] w_word;

   // asm_word already includes this cycle's capture so the final byte
   // can be committed to the output register on the same edge.
   always_comb begin
      w_word = r_word;
      if (cap_en) begin
         w_word[{cap_lane, 3'b000} +: 8] = cap_byte;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_word <= '0;
      end else if (load) begin
         r_word <= load_word;
      end else begin
         r_word <= w_word;
      end
   end

   assign asm_word = w_word;
   assign rd_byte  = r_word[{rd_lane, 3'b000} +: 8];

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_bus_arbiter                                                  |
// | Shares the byte-wide memory/IO bus between instruction fetch and |
// | the MEM stage, serialising accesses into byte beats.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int         ADDR_W = c_INST_ADDR_W,
   parameter logic [1:0] IO_SEL = c_IO_SEL
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               if_req_in,
   input  logic [ADDR_W-1:0]  if_addr_in,
   input  logic               if_cancel_in,
   output logic               if_done_out,
   output logic [c_REG_W-1:0] if_data_out,
   input  logic               d_req_in,
   input  logic               d_we_in,
   input  logic [2:0]         d_len_in,
   input  logic [ADDR_W-1:0]  d_addr_in,
   input  logic [c_REG_W-1:0] d_wdata_in,
   output logic               d_done_out,
   output logic [c_REG_W-1:0] d_rdata_out,
   input  logic               io_buffer_full,
   input  logic [7:0]         mem_din,
   output logic [7:0]         mem_dout,
   output logic [ADDR_W-1:0]  mem_a,
   output logic               mem_wr
);

   state_t              r_state, w_next_state;
   logic [2:0]          r_count, r_len;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_last_data;
   logic                r_rd_pend;
   logic [1:0]          r_pend_lane;

   logic [ADDR_W-1:0]   w_beat_addr, w_mem_a;
   logic                w_last, w_if_ok, w_d_ok, w_io_hold;
   logic                w_grant_if, w_grant_d, w_rd_beat, w_wr_beat, w_advance;
   logic                w_done_if, w_done_d;
   logic [c_REG_W-1:0]  w_asm_word;
   logic [7:0]          w_wr_byte;

   assign w_beat_addr = r_addr + {{(ADDR_W-3){1'b0}}, r_count};
   assign w_last      = (r_count + 3'd1) == r_len;
   assign w_if_ok     = if_req_in && !if_done_out;
   assign w_d_ok      = d_req_in && !d_done_out;
   assign w_io_hold   = (w_beat_addr[17:16] == IO_SEL) && io_buffer_full;

   always_comb begin
      w_next_state = r_state;
      w_grant_if   = 1'b0;
      w_grant_d    = 1'b0;
      w_rd_beat    = 1'b0;
      w_wr_beat    = 1'b0;
      w_advance    = 1'b0;
      w_done_if    = 1'b0;
      w_done_d     = 1'b0;
      w_mem_a      = '0;
      case (r_state)
         ST_IDLE: begin
            if (rdy_in) begin
               if (w_if_ok && (!w_d_ok || r_last_data)) begin
                  w_grant_if   = 1'b1;
                  w_next_state = ST_IF_RD;
               end else if (w_d_ok) begin
                  w_grant_d    = 1'b1;
                  w_next_state = d_we_in ? ST_D_WR : ST_D_RD;
               end
            end
         end
         ST_IF_RD, ST_D_RD: begin
            if (r_count != r_len) begin
               w_mem_a = w_beat_addr;
            end
            // A flush is honoured even while paused so a stale fetch never completes.
            if (r_state == ST_IF_RD && if_cancel_in) begin
               w_next_state = ST_IDLE;
            end else if (rdy_in) begin
               if (r_count != r_len) begin
                  w_rd_beat = 1'b1;
                  w_advance = 1'b1;
               end else begin
                  w_next_state = ST_IDLE;
                  w_done_if    = (r_state == ST_IF_RD);
                  w_done_d     = (r_state == ST_D_RD);
               end
            end
         end
         ST_D_WR: begin
            w_mem_a = w_beat_addr;
            if (rdy_in) begin
               if (w_io_hold) begin
                  w_next_state = ST_IO_WAIT;
               end else begin
                  w_wr_beat = 1'b1;
               end
            end
         end
         ST_IO_WAIT: begin
            w_mem_a   = w_beat_addr;
            w_wr_beat = rdy_in && !io_buffer_full;
         end
         default: w_next_state = ST_IDLE;
      endcase

      if (w_wr_beat) begin
         w_advance = 1'b1;
         if (w_last) begin
            w_next_state = ST_IDLE;
            w_done_d     = 1'b1;
         end else begin
            w_next_state = ST_D_WR;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state     <= ST_IDLE;
         r_count     <= 3'd0;
         r_len       <= 3'd0;
         r_addr      <= '0;
         r_last_data <= 1'b0;
         r_rd_pend   <= 1'b0;
         r_pend_lane <= 2'd0;
         if_done_out <= 1'b0;
         d_done_out  <= 1'b0;
         if_data_out <= '0;
         d_rdata_out <= '0;
      end else begin
         r_state     <= w_next_state;
         r_rd_pend   <= w_rd_beat;
         r_pend_lane <= r_count[1:0];
         if_done_out <= w_done_if;
         d_done_out  <= w_done_d;
         if (w_grant_if || w_grant_d) begin
            r_count     <= 3'd0;
            r_addr      <= w_grant_if ? if_addr_in : d_addr_in;
            r_len       <= w_grant_if ? 3'd4 : norm_len(d_len_in);
            r_last_data <= w_grant_d;
         end else if (w_advance) begin
            r_count <= r_count + 3'd1;
         end
         if (w_done_if) begin
            if_data_out <= w_asm_word;
         end
         if (w_done_d && r_state == ST_D_RD) begin
            d_rdata_out <= w_asm_word;
         end
      end
   end

   // Reads start from zero so short loads come out zero-extended.
   mem_byte_assembler u_asm (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .load      (w_grant_if || w_grant_d),
      .load_word ((w_grant_d && d_we_in) ? d_wdata_in : '0),
      .cap_en    (r_rd_pend),
      .cap_lane  (r_pend_lane),
      .cap_byte  (mem_din),
      .rd_lane   (r_count[1:0]),
      .asm_word  (w_asm_word),
      .rd_byte   (w_wr_byte)
   );

   assign mem_a    = w_mem_a;
   assign mem_wr   = w_wr_beat;
   assign mem_dout = (r_state == ST_D_WR || r_state == ST_IO_WAIT) ? w_wr_byte : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_bus_arbiter                                               |
// | Directed vector bench for mem_bus_arbiter with a byte memory.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mem_bus_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        if_req_in = 1'b0, if_cancel_in = 1'b0;
   logic [31:0] if_addr_in = '0;
   logic        if_done_out;
   logic [31:0] if_data_out;
   logic        d_req_in = 1'b0, d_we_in = 1'b0;
   logic [2:0]  d_len_in = 3'd0;
   logic [31:0] d_addr_in = '0, d_wdata_in = '0;
   logic        d_done_out;
   logic [31:0] d_rdata_out;
   logic        io_buffer_full = 1'b0;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   int n_cmp = 0;
   int n_err = 0;

   mem_bus_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_cancel_in(if_cancel_in),
      .if_done_out(if_done_out), .if_data_out(if_data_out),
      .d_req_in(d_req_in), .d_we_in(d_we_in), .d_len_in(d_len_in),
      .d_addr_in(d_addr_in), .d_wdata_in(d_wdata_in),
      .d_done_out(d_done_out), .d_rdata_out(d_rdata_out),
      .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk_in = ~clk_in;

   // Byte memory: read data one cycle after its address, IO space not stored.
   logic [7:0] mem [0:1023];
   bit         mem_loaded = 1'b0;
   always @(posedge clk_in) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem[10'h100] <= 8'h11; mem[10'h101] <= 8'h22; mem[10'h102] <= 8'h33; mem[10'h103] <= 8'h44;
         mem[10'h104] <= 8'h55; mem[10'h105] <= 8'h66; mem[10'h106] <= 8'h77; mem[10'h107] <= 8'h88;
         mem[10'h200] <= 8'hDE; mem[10'h201] <= 8'hAD; mem[10'h202] <= 8'hBE; mem[10'h203] <= 8'hEF;
         mem[10'h3FF] <= 8'hEE; mem[10'h000] <= 8'hAB; mem[10'h001] <= 8'hCD; mem[10'h002] <= 8'hEF;
         mem_din    <= 8'h00;
         mem_loaded <= 1'b1;
      end else begin
         mem_din <= mem[mem_a[9:0]];
         if (mem_wr && mem_a[17:16] != 2'b11) mem[mem_a[9:0]] <= mem_dout;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in); #1;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  len;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          beats;
      int          done_cyc;
   } vec_t;

   vec_t vecs [12];

   task automatic run_vec(input vec_t v);
      int          dc;
      logic [31:0] rd, wb;
      step();
      d_req_in = 1'b1; d_we_in = v.we; d_len_in = v.len; d_addr_in = v.addr; d_wdata_in = v.wdata;
      dc = 0; rd = '0;
      for (int c = 1; c <= 40 && dc == 0; c++) begin
         step(); @(negedge clk_in);
         if (c <= v.beats) begin
            check("beat_addr", mem_a, v.addr + c - 1);
            check("beat_wr", {31'b0, mem_wr}, {31'b0, v.we});
            if (v.we) begin
               wb = v.wdata >> (8 * (c - 1));
               check("beat_dout", {24'b0, mem_dout}, {24'b0, wb[7:0]});
            end
         end
         if (d_done_out) begin
            dc = c; rd = d_rdata_out; d_req_in = 1'b0;
         end
      end
      d_req_in = 1'b0;
      check("done_cycle", dc, v.done_cyc);
      if (!v.we) check("rdata", rd, v.exp_rdata);
      step(); @(negedge clk_in);
      check("done_pulse", {31'b0, d_done_out}, 32'd0);
   endtask

   // Runs concurrent IF / data read requests; reports done cycles and data.
   task automatic both_ports(input bit ie, input logic [31:0] ia, input bit de,
                             input logic [2:0] dl, input logic [31:0] da,
                             output int ic, output int dc, output logic [31:0] a1,
                             output logic [31:0] idata, output logic [31:0] ddata);
      ic = 0; dc = 0; a1 = '0; idata = '0; ddata = '0;
      step();
      if_req_in = ie; if_addr_in = ia;
      d_req_in = de; d_we_in = 1'b0; d_len_in = dl; d_addr_in = da;
      for (int c = 1; c <= 60; c++) begin
         step(); @(negedge clk_in);
         if (c == 1) a1 = mem_a;
         if (if_done_out && ic == 0) begin ic = c; idata = if_data_out; if_req_in = 1'b0; end
         if (d_done_out && dc == 0)  begin dc = c; ddata = d_rdata_out; d_req_in = 1'b0; end
         if ((!ie || ic != 0) && (!de || dc != 0)) break;
      end
      if_req_in = 1'b0; d_req_in = 1'b0;
      step(); @(negedge clk_in);
      check("pair_pulse", {30'b0, if_done_out, d_done_out}, 32'd0);
   endtask

   initial begin
      int          ic, dc;
      logic [31:0] a1, idata, ddata;
      bit          bad;

      vecs[0]  = '{we:1'b0, len:3'd4, addr:32'h0000_0100, wdata:32'h0, exp_rdata:32'h4433_2211, beats:4, done_cyc:6};
      vecs[1]  = '{we:1'b0, len:3'd1, addr:32'h0000_0102, wdata:32'h0, exp_rdata:32'h0000_0033, beats:1, done_cyc:3};
      vecs[2]  = '{we:1'b0, len:3'd2, addr:32'h0000_0105, wdata:32'h0, exp_rdata:32'h0000_7766, beats:2, done_cyc:4};
      vecs[3]  = '{we:1'b0, len:3'd3, addr:32'h0000_0104, wdata:32'h0, exp_rdata:32'h8877_6655, beats:4, done_cyc:6};
      vecs[4]  = '{we:1'b0, len:3'd4, addr:32'hFFFF_FFFF, wdata:32'h0, exp_rdata:32'hEFCD_ABEE, beats:4, done_cyc:6};
      vecs[5]  = '{we:1'b1, len:3'd4, addr:32'h0000_0010, wdata:32'hCAFE_BABE, exp_rdata:32'h0, beats:4, done_cyc:5};
      vecs[6]  = '{we:1'b1, len:3'd2, addr:32'h0000_0020, wdata:32'h1234_5678, exp_rdata:32'h0, beats:2, done_cyc:3};
      vecs[7]  = '{we:1'b1, len:3'd1, addr:32'h0000_0024, wdata:32'h0000_00A7, exp_rdata:32'h0, beats:1, done_cyc:2};
      vecs[8]  = '{we:1'b0, len:3'd4, addr:32'h0000_0010, wdata:32'h0, exp_rdata:32'hCAFE_BABE, beats:4, done_cyc:6};
      vecs[9]  = '{we:1'b0, len:3'd4, addr:32'h0000_0020, wdata:32'h0, exp_rdata:32'h0000_5678, beats:4, done_cyc:6};
      vecs[10] = '{we:1'b0, len:3'd1, addr:32'h0000_0024, wdata:32'h0, exp_rdata:32'h0000_00A7, beats:1, done_cyc:3};
      vecs[11] = '{we:1'b0, len:3'd7, addr:32'h0000_0100, wdata:32'h0, exp_rdata:32'h4433_2211, beats:4, done_cyc:6};

      // Reset state
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("rst_mem_wr",  {31'b0, mem_wr}, 32'd0);
      check("rst_mem_a",   mem_a, 32'd0);
      check("rst_mem_dout", {24'b0, mem_dout}, 32'd0);
      check("rst_dones",   {30'b0, if_done_out, d_done_out}, 32'd0);
      check("rst_if_data", if_data_out, 32'd0);
      check("rst_d_rdata", d_rdata_out, 32'd0);
      step(); rst_in = 1'b1;
      repeat (2) step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // Both pending, previous grant data: IF first, data granted in IF's done cycle
      both_ports(1'b1, 32'h200, 1'b1, 3'd4, 32'h104, ic, dc, a1, idata, ddata);
      check("alt_first_addr", a1, 32'h200);
      check("alt_if_cycle", ic, 6);
      check("alt_if_data", idata, 32'hEFBE_ADDE);
      check("alt_d_cycle", dc, 12);
      check("alt_d_data", ddata, 32'h8877_6655);

      // Previous grant IF: data wins when both are pending
      both_ports(1'b1, 32'h100, 1'b0, 3'd4, 32'h0, ic, dc, a1, idata, ddata);
      check("if_only_cycle", ic, 6);
      check("if_only_data", idata, 32'h4433_2211);
      both_ports(1'b1, 32'h200, 1'b1, 3'd1, 32'h101, ic, dc, a1, idata, ddata);
      check("prio_first_addr", a1, 32'h101);
      check("prio_d_cycle", dc, 3);
      check("prio_d_data", ddata, 32'h0000_0022);
      check("prio_if_cycle", ic, 9);
      check("prio_if_data", idata, 32'hEFBE_ADDE);

      // IO hold: UART full for 5 cycles
      step();
      io_buffer_full = 1'b1;
      d_req_in = 1'b1; d_we_in = 1'b1; d_len_in = 3'd1; d_addr_in = 32'h0003_0000; d_wdata_in = 32'h41;
      for (int c = 1; c <= 5; c++) begin
         step(); @(negedge clk_in);
         check("io_hold_wr", {31'b0, mem_wr}, 32'd0);
      end
      step(); io_buffer_full = 1'b0; @(negedge clk_in);
      check("io_beat_wr", {31'b0, mem_wr}, 32'd1);
      check("io_beat_dout", {24'b0, mem_dout}, 32'h41);
      check("io_beat_addr", mem_a, 32'h0003_0000);
      check("io_no_early_done", {31'b0, d_done_out}, 32'd0);
      step(); @(negedge clk_in);
      check("io_done", {31'b0, d_done_out}, 32'd1);
      d_req_in = 1'b0; d_we_in = 1'b0;

      // Cancel at the second IF beat with a data request pending
      step();
      if_req_in = 1'b1; if_addr_in = 32'h200;
      d_req_in = 1'b1; d_we_in = 1'b0; d_len_in = 3'd1; d_addr_in = 32'h100;
      bad = 1'b0; dc = 0; ddata = '0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 2) begin if_cancel_in = 1'b1; if_req_in = 1'b0; end
         if (c == 3) if_cancel_in = 1'b0;
         @(negedge clk_in);
         if (c == 1) check("cxl_beat0", mem_a, 32'h200);
         if (c == 2) check("cxl_beat1", mem_a, 32'h201);
         if (c == 3) check("cxl_idle", mem_a, 32'h0);
         if (c == 4) check("cxl_d_beat", mem_a, 32'h100);
         if (if_done_out) bad = 1'b1;
         if (d_done_out && dc == 0) begin dc = c; ddata = d_rdata_out; d_req_in = 1'b0; end
      end
      d_req_in = 1'b0;
      check("cxl_no_if_done", {31'b0, bad}, 32'd0);
      check("cxl_d_cycle", dc, 6);
      check("cxl_d_data", ddata, 32'h11);

      // rdy_in low for 3 cycles mid word read
      step();
      d_req_in = 1'b1; d_we_in = 1'b0; d_len_in = 3'd4; d_addr_in = 32'h100;
      dc = 0; ddata = '0;
      for (int c = 1; c <= 30 && dc == 0; c++) begin
         step();
         if (c == 2) rdy_in = 1'b0;
         if (c == 5) rdy_in = 1'b1;
         @(negedge clk_in);
         if (c == 4) check("rdy_hold_addr", mem_a, 32'h101);
         if (d_done_out) begin dc = c; ddata = d_rdata_out; d_req_in = 1'b0; end
      end
      rdy_in = 1'b1; d_req_in = 1'b0;
      check("rdy_done_cycle", dc, 9);
      check("rdy_data", ddata, 32'h4433_2211);

      // Asynchronous reset in the middle of a word store
      step();
      d_req_in = 1'b1; d_we_in = 1'b1; d_len_in = 3'd4; d_addr_in = 32'h40; d_wdata_in = 32'h1122_3344;
      step(); @(negedge clk_in);
      check("sw_pre_rst_wr", {31'b0, mem_wr}, 32'd1);
      step(); @(negedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      check("rst_async_wr", {31'b0, mem_wr}, 32'd0);
      check("rst_async_a", mem_a, 32'd0);
      d_req_in = 1'b0; d_we_in = 1'b0;
      @(posedge clk_in); @(posedge clk_in); #1 rst_in = 1'b1;
      bad = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         step(); @(negedge clk_in);
         if (d_done_out || if_done_out || mem_wr) bad = 1'b1;
      end
      check("rst_quiet", {31'b0, bad}, 32'd0);
      check("rst_rdata_clr", d_rdata_out, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
